// File: rtl/rmw_counter_arbiter_if.sv
// Request/response bundle for rmw_counter_arbiter: two requesters in, one response stream out.
interface rmw_counter_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_inc;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_inc;
  logic          resp_valid;
  logic          resp_id;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] resp_data;
  logic          busy_init;

  modport master (
    output req0_valid, req0_addr, req0_inc, req1_valid, req1_addr, req1_inc,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_addr, resp_data, busy_init
  );

  modport slave (
    input  req0_valid, req0_addr, req0_inc, req1_valid, req1_addr, req1_inc,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_addr, resp_data, busy_init
  );
endinterface

// File: rtl/rmw_counter_arbiter.sv
// Counter array shared by two requesters through a round-robin, fixed-latency
// read-increment-write pipeline; the array is cleared after every reset.
module rmw_counter_arbiter #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 32,
  parameter int SAT   = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rmw_counter_arbiter_if.slave bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_ptr, clr_ptr_nxt;
  logic          rr_last, rr_last_nxt;
  logic          gnt0, gnt1;

  logic [DW-1:0] mem [DEPTH];

  logic          vld_p0;
  logic          id_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] inc_p0;
  logic [DW-1:0] sum_p0;

  logic          vld_p1;
  logic          id_p1;
  logic [AW-1:0] addr_p1;
  logic [DW-1:0] data_p1;

  function automatic logic [DW-1:0] add_counter(input logic [DW-1:0] old_val,
                                                input logic [DW-1:0] inc_val);
    logic [DW:0] sum_ext;
    sum_ext = {1'b0, old_val} + {1'b0, inc_val};
    if (SAT != 0 && sum_ext[DW]) return '1;
    return sum_ext[DW-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  // rr_last names the requester served most recently; on contention the other one wins.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    rr_last_nxt = rr_last;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    case (state)
      ST_INIT: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == AW'(DEPTH - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || rr_last);
        gnt1 = bus.req1_valid && (!bus.req0_valid || !rr_last);
        if (gnt0)      rr_last_nxt = 1'b0;
        else if (gnt1) rr_last_nxt = 1'b1;
      end
    endcase
  end

  // Stage p0: granted request captured at the handshake edge.
  always_ff @(posedge clk) begin
    if (gnt0 || gnt1) begin
      id_p0   <= gnt1;
      addr_p0 <= gnt1 ? bus.req1_addr : bus.req0_addr;
      inc_p0  <= gnt1 ? bus.req1_inc  : bus.req0_inc;
    end
  end

  // The previous request's write lands on the same edge this one enters p0,
  // so the async read below always sees it and needs no bypass.
  assign sum_p0 = add_counter(mem[addr_p0], inc_p0);

  always_ff @(posedge clk) begin
    if (state == ST_INIT) mem[clr_ptr] <= '0;
    else if (vld_p0)      mem[addr_p0] <= sum_p0;
  end

  // Stage p1: write-back result presented as the response pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      id_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p0 <= gnt0 || gnt1;
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        id_p1   <= id_p0;
        addr_p1 <= addr_p0;
        data_p1 <= sum_p0;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.resp_valid = vld_p1;
  assign bus.resp_id    = id_p1;
  assign bus.resp_addr  = addr_p1;
  assign bus.resp_data  = data_p1;
  assign bus.busy_init  = (state == ST_INIT);

endmodule

// File: tb/tb_rmw_counter_arbiter.sv
// Bench for rmw_counter_arbiter: wrapping and saturating instances driven in lockstep,
// responses checked against a scoreboard fed at each handshake.
module tb_rmw_counter_arbiter;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rmw_counter_arbiter_if #(.AW(AW), .DW(DW)) if0 ();
  rmw_counter_arbiter_if #(.AW(AW), .DW(DW)) if1 ();

  assign if1.req0_valid = if0.req0_valid;
  assign if1.req0_addr  = if0.req0_addr;
  assign if1.req0_inc   = if0.req0_inc;
  assign if1.req1_valid = if0.req1_valid;
  assign if1.req1_addr  = if0.req1_addr;
  assign if1.req1_inc   = if0.req1_inc;

  rmw_counter_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SAT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0));
  rmw_counter_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  typedef struct {
    logic          id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] m1 [DEPTH];
  int            checks = 0;
  int            passed = 0;
  int            cyc    = 0;

  // Expected result of one accepted request; instance 1 saturates, instance 0 wraps.
  task automatic sb_push(input int k, input logic id, input logic [AW-1:0] a,
                         input logic [DW-1:0] inc);
    logic [DW:0] s;
    exp_t        e;
    if (k == 0) s = {1'b0, m0[a]} + {1'b0, inc};
    else        s = {1'b0, m1[a]} + {1'b0, inc};
    e.id   = id;
    e.addr = a;
    e.due  = cyc + 2;
    e.data = (k == 1 && s[DW]) ? '1 : s[DW-1:0];
    if (k == 0) begin m0[a] = e.data; q0.push_back(e); end
    else        begin m1[a] = e.data; q1.push_back(e); end
  endtask

  task automatic sb_pop(input int k, input logic rv, input logic rid,
                        input logic [AW-1:0] ra, input logic [DW-1:0] rd);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    if (have) begin
      checks++;
      if (rv !== 1'b1 || rid !== e.id || ra !== e.addr || rd !== e.data)
        $display("FAIL resp dut%0d cyc%0d: got v=%b id=%b addr=%0d data=%h, want v=1 id=%b addr=%0d data=%h",
                 k, cyc, rv, rid, ra, rd, e.id, e.addr, e.data);
      else passed++;
    end else if (rv !== 1'b0) begin
      checks++;
      $display("FAIL spurious_resp dut%0d cyc%0d: got resp_valid=%b, want 0", k, cyc, rv);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      sb_pop(0, if0.resp_valid, if0.resp_id, if0.resp_addr, if0.resp_data);
      sb_pop(1, if1.resp_valid, if1.resp_id, if1.resp_addr, if1.resp_data);
      checks++;
      if ((if0.req0_ready && !if0.req0_valid) || (if0.req1_ready && !if0.req1_valid) ||
          (if0.req0_ready && if0.req1_ready) ||
          if1.req0_ready !== if0.req0_ready || if1.req1_ready !== if0.req1_ready)
        $display("FAIL ready_rule cyc%0d: got r0=%b/%b r1=%b/%b v0=%b v1=%b, want one-hot ready gated by valid",
                 cyc, if0.req0_ready, if1.req0_ready, if0.req1_ready, if1.req1_ready,
                 if0.req0_valid, if0.req1_valid);
      else passed++;
      if (if0.req0_ready === 1'b1) begin
        sb_push(0, 1'b0, if0.req0_addr, if0.req0_inc);
        sb_push(1, 1'b0, if0.req0_addr, if0.req0_inc);
      end
      if (if0.req1_ready === 1'b1) begin
        sb_push(0, 1'b1, if0.req1_addr, if0.req1_inc);
        sb_push(1, 1'b1, if0.req1_addr, if0.req1_inc);
      end
    end
  end

  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] i0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] i1,
                      output logic r0, output logic r1);
    @(posedge clk);
    #1;
    if0.req0_valid = v0; if0.req0_addr = a0; if0.req0_inc = i0;
    if0.req1_valid = v1; if0.req1_addr = a1; if0.req1_inc = i1;
    @(negedge clk);
    r0 = if0.req0_ready;
    r1 = if0.req1_ready;
  endtask

  task automatic idle(input int n);
    logic r0, r1;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, r0, r1);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < DEPTH; i++) begin m0[i] = '0; m1[i] = '0; end
  endtask

  // Releases reset and counts busy_init cycles; no comparisons here.
  task automatic release_and_count(output int n, output bit rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if0.busy_init !== 1'b1 || if1.busy_init !== 1'b1) break;
      n++;
      if (if0.req0_ready !== 1'b0 || if0.req1_ready !== 1'b0 ||
          if1.req0_ready !== 1'b0 || if1.req1_ready !== 1'b0) rdy_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    int   n;
    bit   rs;
    logic r0, r1;
    #2;
    checks++;
    if (if0.busy_init !== 1'b1 || if0.resp_valid !== 1'b0 || if0.resp_id !== 1'b0 ||
        if0.resp_addr !== '0 || if0.resp_data !== '0 || if0.req0_ready !== 1'b0 ||
        if0.req1_ready !== 1'b0 || if1.busy_init !== 1'b1 || if1.resp_valid !== 1'b0)
      $display("FAIL reset_state: got busy=%b rv=%b id=%b addr=%0d data=%h r0=%b r1=%b, want busy=1 rest 0",
               if0.busy_init, if0.resp_valid, if0.resp_id, if0.resp_addr, if0.resp_data,
               if0.req0_ready, if0.req1_ready);
    else passed++;
    // Valids held high during the clear to show the readies stay low.
    if0.req0_valid = 1'b1; if0.req0_addr = 3'd0; if0.req0_inc = '0;
    if0.req1_valid = 1'b1; if0.req1_addr = 3'd0; if0.req1_inc = '0;
    release_and_count(n, rs);
    checks++;
    if (n != 8) $display("FAIL busy_init_len: got %0d cycles, want 8", n);
    else passed++;
    checks++;
    if (rs) $display("FAIL ready_in_init: got ready=1 during init, want 0");
    else passed++;
    checks++;
    if (if0.req0_ready !== 1'b1 || if0.req1_ready !== 1'b0)
      $display("FAIL first_grant: got r0=%b r1=%b, want r0=1 r1=0", if0.req0_ready, if0.req1_ready);
    else passed++;
    for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), '0, 1'b0, '0, '0, r0, r1);
    idle(3);
  endtask

  task automatic test_single_req0();
    logic r0, r1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'd3, 32'd5, 1'b0, '0, '0, r0, r1);
      checks++;
      if (r0 !== 1'b1 || r1 !== 1'b0) $display("FAIL req0_ready[%0d]: got r0=%b r1=%b, want 1/0", i, r0, r1);
      else passed++;
    end
    idle(3);
  endtask

  task automatic test_round_robin();
    logic r0, r1;
    step(1'b0, '0, '0, 1'b1, 3'd1, '0, r0, r1);
    checks++;
    if (r1 !== 1'b1) $display("FAIL rr_prime: got r1=%b, want 1", r1);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd1, 32'd1, 1'b1, 3'd1, 32'd2, r0, r1);
      checks++;
      if (r0 !== ((i % 2) == 0) || r1 !== ((i % 2) == 1))
        $display("FAIL rr_grant[%0d]: got r0=%b r1=%b, want r0=%b", i, r0, r1, (i % 2) == 0);
      else passed++;
    end
    idle(3);
  endtask

  task automatic test_saturation();
    logic r0, r1;
    step(1'b1, 3'd2, '1, 1'b0, '0, '0, r0, r1);
    step(1'b1, 3'd2, 32'd2, 1'b0, '0, '0, r0, r1);
    idle(2);
    checks++;
    if (if0.resp_valid !== 1'b1 || if0.resp_data !== 32'h1)
      $display("FAIL wrap: got v=%b data=%h, want v=1 data=00000001", if0.resp_valid, if0.resp_data);
    else passed++;
    checks++;
    if (if1.resp_valid !== 1'b1 || if1.resp_data !== 32'hFFFF_FFFF)
      $display("FAIL saturate: got v=%b data=%h, want v=1 data=ffffffff", if1.resp_valid, if1.resp_data);
    else passed++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic r0, r1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'd5, 32'd9, 1'b1, 3'd7, 32'd1, r0, r1);
      checks++;
      if (r1 !== 1'b1 || r0 !== 1'b0) $display("FAIL req1_only[%0d]: got r0=%b r1=%b, want 0/1", i, r0, r1);
      else passed++;
    end
    idle(3);
  endtask

  task automatic test_reset_inflight();
    int   n;
    bit   rs;
    logic r0, r1;
    step(1'b1, 3'd1, 32'd3, 1'b0, '0, '0, r0, r1);
    step(1'b0, '0, '0, 1'b1, 3'd1, 32'd4, r0, r1);
    @(posedge clk);
    #1;
    if0.req1_valid = 1'b0;
    checks++;
    if (if0.resp_valid !== 1'b1) $display("FAIL inflight_pre: got resp_valid=%b, want 1", if0.resp_valid);
    else passed++;
    reset_n = 1'b0;
    #1;
    checks++;
    if (if0.resp_valid !== 1'b0 || if1.resp_valid !== 1'b0 || if0.busy_init !== 1'b1)
      $display("FAIL async_drop: got rv=%b/%b busy=%b, want 0/0 busy=1",
               if0.resp_valid, if1.resp_valid, if0.busy_init);
    else passed++;
    clear_model();
    repeat (2) @(posedge clk);
    release_and_count(n, rs);
    checks++;
    if (n != 8 || rs) $display("FAIL reinit: got %0d busy cycles ready_seen=%b, want 8 and 0", n, rs);
    else passed++;
    step(1'b1, 3'd1, '0, 1'b0, '0, '0, r0, r1);
    idle(3);
  endtask

  initial begin
    if0.req0_valid = 1'b0; if0.req0_addr = '0; if0.req0_inc = '0;
    if0.req1_valid = 1'b0; if0.req1_addr = '0; if0.req1_inc = '0;
    clear_model();
    test_reset();
    test_single_req0();
    test_round_robin();
    test_saturation();
    test_back_to_back();
    test_reset_inflight();
    checks++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL drain: got %0d/%0d responses outstanding, want 0", q0.size(), q1.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1);
  end
endmodule
